// File: rtl/bonus_pos_mux_n.sv
// Multi-channel falling-bonus position tracker.
// Each channel spawns at a brick-hit point, falls FALL_STEP pixels per frame,
// and parks at home when collected, when it reaches the bottom, or in pre-start.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | parked at HOME_X/HOME_Y, invisible, free for spawn
//   FALLING | visible, Y advances on each startOfFrame
module bonus_pos_mux_n #(
    parameter int N_CH      = 4,
    parameter int W         = 11,
    parameter int HOME_X    = 0,
    parameter int HOME_Y    = 0,
    parameter int FALL_STEP = 2,
    parameter int BOTTOM_Y  = 479
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              preStart,
    input  logic              spawnReq,
    input  logic [W-1:0]      spawnX,
    input  logic [W-1:0]      spawnY,
    input  logic [N_CH-1:0]   collect,
    output logic [N_CH*W-1:0] topLeftX,
    output logic [N_CH*W-1:0] topLeftY,
    output logic [N_CH-1:0]   bonusActive,
    output logic              spawnDrop
);

    typedef enum logic {IDLE = 1'b0, FALLING = 1'b1} state_t;

    localparam logic [W-1:0] HOME_X_W   = W'(HOME_X);
    localparam logic [W-1:0] HOME_Y_W   = W'(HOME_Y);
    localparam logic [W:0]   STEP_EXT   = (W+1)'(FALL_STEP);
    localparam logic [W:0]   BOTTOM_EXT = (W+1)'(BOTTOM_Y);

    state_t         state_q [N_CH];
    state_t         state_d [N_CH];
    logic [W-1:0]   x_q     [N_CH];
    logic [W-1:0]   x_d     [N_CH];
    logic [W-1:0]   y_q     [N_CH];
    logic [W-1:0]   y_d     [N_CH];
    logic [W:0]     y_sum   [N_CH];
    logic           drop_q, drop_d;
    logic [N_CH-1:0] alloc;
    logic           any_idle;

    // State register: async reset parks every channel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= HOME_X_W;
                y_q[i]     <= HOME_Y_W;
            end
            drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            drop_q <= drop_d;
        end
    end

    // Pick the lowest-index channel that is idle at the start of this cycle;
    // channels freed this cycle are not visible here until the next one.
    always_comb begin
        alloc    = '0;
        any_idle = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!any_idle && state_q[i] == IDLE) begin
                alloc[i] = 1'b1;
                any_idle = 1'b1;
            end
        end
    end

    // Extended-width fall sum so a Y near the top of the range cannot wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            y_sum[i] = {1'b0, y_q[i]} + STEP_EXT;
        end
    end

    // Next state: preStart > collect > frame move; spawn only touches idle channels.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            if (preStart) begin
                state_d[i] = IDLE;
                x_d[i]     = HOME_X_W;
                y_d[i]     = HOME_Y_W;
            end else if (state_q[i] == FALLING) begin
                if (collect[i] || (startOfFrame && y_sum[i] >= BOTTOM_EXT)) begin
                    state_d[i] = IDLE;
                    x_d[i]     = HOME_X_W;
                    y_d[i]     = HOME_Y_W;
                end else if (startOfFrame) begin
                    y_d[i] = y_sum[i][W-1:0];
                end
            end else if (spawnReq && alloc[i]) begin
                state_d[i] = FALLING;
                x_d[i]     = spawnX;
                y_d[i]     = spawnY;
            end
        end
        drop_d = spawnReq && !preStart && !any_idle;
    end

    // Outputs: pack the registered per-channel state onto the flat buses.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            topLeftX[i*W +: W] = x_q[i];
            topLeftY[i*W +: W] = y_q[i];
            bonusActive[i]     = (state_q[i] == FALLING);
        end
        spawnDrop = drop_q;
    end

endmodule

// File: tb/tb_bonus_pos_mux_n.sv
// Directed bench for bonus_pos_mux_n with hand-computed expectations.
module tb_bonus_pos_mux_n;

    localparam int N = 4;
    localparam int W = 11;

    logic           clk = 1'b0;
    logic           resetN;
    logic           startOfFrame, preStart, spawnReq;
    logic [W-1:0]   spawnX, spawnY;
    logic [N-1:0]   collect;
    logic [N*W-1:0] topLeftX, topLeftY;
    logic [N-1:0]   bonusActive;
    logic           spawnDrop;

    int n_chk  = 0;
    int n_fail = 0;

    int       ex [N];
    int       ey [N];
    logic [N-1:0] ea;
    logic     ed;

    bonus_pos_mux_n dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .preStart     (preStart),
        .spawnReq     (spawnReq),
        .spawnX       (spawnX),
        .spawnY       (spawnY),
        .collect      (collect),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .bonusActive  (bonusActive),
        .spawnDrop    (spawnDrop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s x%0d", tag, i), 32'(topLeftX[i*W +: W]), 32'(ex[i]));
            chk($sformatf("%s y%0d", tag, i), 32'(topLeftY[i*W +: W]), 32'(ey[i]));
        end
        chk({tag, " active"}, 32'(bonusActive), 32'(ea));
        chk({tag, " drop"}, 32'(spawnDrop), 32'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        spawnReq     = 1'b0;
        collect      = '0;
    endtask

    task automatic spawn(input int x, input int y);
        spawnX   = W'(x);
        spawnY   = W'(y);
        spawnReq = 1'b1;
        tick();
    endtask

    task automatic set_ch(input int i, input int x, input int y, input logic a);
        ex[i] = x;
        ey[i] = y;
        ea[i] = a;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; preStart = 1'b0; spawnReq = 1'b0;
        spawnX = '0; spawnY = '0; collect = '0;
        for (int i = 0; i < N; i++) set_ch(i, 0, 0, 1'b0);
        ed = 1'b0;
        #12;
        check_all("reset");
        @(posedge clk); #1;
        resetN = 1'b1;
        tick();

        spawn(100, 50);
        set_ch(0, 100, 50, 1'b1);
        check_all("spawn0");

        for (int k = 0; k < 3; k++) begin
            startOfFrame = 1'b1;
            tick();
        end
        ey[0] = 56;
        check_all("fall3");

        spawn(200, 476); set_ch(1, 200, 476, 1'b1);
        spawn(300, 100); set_ch(2, 300, 100, 1'b1);
        spawn(400, 200); set_ch(3, 400, 200, 1'b1);
        check_all("full");

        spawn(7, 7);
        ed = 1'b1;
        check_all("drop");
        tick();
        ed = 1'b0;
        check_all("drop_clear");

        startOfFrame = 1'b1;
        tick();
        ey[0] = 58; ey[1] = 478; ey[2] = 102; ey[3] = 202;
        check_all("near_bottom");

        startOfFrame = 1'b1;
        tick();
        ey[0] = 60; ey[2] = 104; ey[3] = 204;
        set_ch(1, 0, 0, 1'b0);
        check_all("retire1");

        spawn(50, 10);
        set_ch(1, 50, 10, 1'b1);
        check_all("refill1");

        collect[2]   = 1'b1;
        startOfFrame = 1'b1;
        spawnX = W'(9); spawnY = W'(9); spawnReq = 1'b1;
        tick();
        ey[0] = 62; ey[1] = 12; ey[3] = 206;
        set_ch(2, 0, 0, 1'b0);
        ed = 1'b1;
        check_all("collect2");

        spawn(123, 45);
        set_ch(2, 123, 45, 1'b1);
        ed = 1'b0;
        check_all("refill2");

        collect[3] = 1'b1;
        tick();
        set_ch(3, 0, 0, 1'b0);
        check_all("collect3");

        preStart = 1'b1;
        spawnX = W'(11); spawnY = W'(11); spawnReq = 1'b1; startOfFrame = 1'b1;
        tick();
        for (int i = 0; i < N; i++) set_ch(i, 0, 0, 1'b0);
        check_all("prestart");
        spawnReq = 1'b1; collect = 4'b1111;
        tick();
        check_all("prestart_hold");
        preStart = 1'b0;

        spawn(20, 300); set_ch(0, 20, 300, 1'b1);
        spawn(1, 490);  set_ch(1, 1, 490, 1'b1);
        check_all("spawn_low");

        startOfFrame = 1'b1;
        tick();
        ey[0] = 302;
        set_ch(1, 0, 0, 1'b0);
        check_all("retire_low");

        startOfFrame = 1'b1;
        spawn(33, 44);
        ey[0] = 304;
        set_ch(1, 33, 44, 1'b1);
        check_all("spawn_sof");

        #3;
        resetN = 1'b0;
        #1;
        for (int i = 0; i < N; i++) set_ch(i, 0, 0, 1'b0);
        ed = 1'b0;
        check_all("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
